// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one cacheline adaptor; CACHE_ARBITER_RR_EN selects round-robin, else D over I.
// Latency: grant-to-resp is adaptor latency + 1 cycle, followed by one DONE bubble before the next grant.
// Backpressure: requesters hold until their *_resp pulse; mem_read/mem_write stay high until mem_resp.
module cache_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_address,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [255:0]   wdata_q, wdata_d;
    logic           write_q, write_d;
    logic           d_req;
    logic           grant_d;

    assign d_req = d_read | d_write;

`ifdef CACHE_ARBITER_RR_EN
    logic favor_d_q, favor_d_d;

    // Under contention, the side not served by the most recent grant wins.
    assign grant_d = d_req && (!i_read || favor_d_q);

    always_ff @(posedge clk) begin
        if (rst) favor_d_q <= 1'b1;
        else     favor_d_q <= favor_d_d;
    end

    always_comb begin
        favor_d_d = favor_d_q;
        if (state_q == IDLE) begin
            if (grant_d)     favor_d_d = 1'b0;
            else if (i_read) favor_d_d = 1'b1;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = SERVE_D;
                    addr_d  = d_address;
                    wdata_d = d_wdata;
                    write_d = d_write;
                end else if (i_read) begin
                    state_d = SERVE_I;
                    addr_d  = i_address;
                    write_d = 1'b0;
                end
            end
            // A requester dropping early does not abort; only mem_resp ends the transfer.
            SERVE_I, SERVE_D: if (mem_resp) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read  = (state_q == SERVE_I) || ((state_q == SERVE_D) && !write_q);
        mem_write = (state_q == SERVE_D) && write_q;
        i_resp    = (state_q == SERVE_I) && mem_resp;
        d_resp    = (state_q == SERVE_D) && mem_resp;
    end

    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: inputs change and outputs are sampled around the falling edge.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    int n_pass = 0;
    int n_checks = 0;

    localparam logic [255:0] PAT_A = {32{8'hAA}};
    localparam logic [255:0] PAT_5 = {32{8'h55}};
    localparam logic [255:0] PAT_B = {32{8'hBB}};
    localparam logic [255:0] PAT_C = {32{8'hC3}};

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
        d_address = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 0;
        tick(); tick(); #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_i_resp", i_resp, 0);
        chk("rst_d_resp", d_resp, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // I-only fill, adaptor answers on the 4th serving cycle
        tick(); rst = 0; i_read = 1; i_address = 32'h60;
        tick(); #1;
        chk("i_mem_read_t1", mem_read, 1);
        chk("i_mem_write_t1", mem_write, 0);
        chk("i_mem_address", mem_address, 32'h60);
        chk("i_no_resp_early", i_resp, 0);
        tick(); tick(); #1;
        chk("i_mem_read_t3", mem_read, 1);
        tick(); mem_resp = 1; mem_rdata = PAT_A; #1;
        chk("i_resp_pulse", i_resp, 1);
        chk("i_rdata", i_rdata, PAT_A);
        chk("i_d_resp_quiet", d_resp, 0);
        tick(); mem_resp = 0; i_read = 0; #1;
        chk("i_done_mem_read", mem_read, 0);
        chk("i_done_resp", i_resp, 0);
        tick();

        // D writeback, then stray mem_resp during DONE
        tick(); d_write = 1; d_address = 32'h1000; d_wdata = PAT_5;
        tick(); #1;
        chk("dw_mem_write", mem_write, 1);
        chk("dw_mem_read", mem_read, 0);
        chk("dw_mem_address", mem_address, 32'h1000);
        chk("dw_mem_wdata", mem_wdata, PAT_5);
        tick(); tick(); #1;
        chk("dw_mem_write_held", mem_write, 1);
        tick(); mem_resp = 1; mem_rdata = PAT_B; #1;
        chk("dw_d_resp", d_resp, 1);
        chk("dw_i_resp_quiet", i_resp, 0);
        tick(); d_write = 0; #1;
        chk("dw_done_mem_write", mem_write, 0);
        chk("dw_stray_done_d_resp", d_resp, 0);
        chk("dw_stray_done_i_resp", i_resp, 0);
        tick(); mem_resp = 0;

        // Contention from a fresh reset
        tick(); rst = 1;
        tick(); rst = 0; i_read = 1; i_address = 32'h80; d_read = 1; d_address = 32'h2000;
`ifdef CACHE_ARBITER_RR_EN
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("rr_mem_address", mem_address, (k % 2 == 0) ? 32'h2000 : 32'h80);
            chk("rr_mem_read", mem_read, 1);
            mem_resp = 1; mem_rdata = PAT_C; #1;
            chk("rr_d_resp", d_resp, (k % 2 == 0) ? 1 : 0);
            chk("rr_i_resp", i_resp, (k % 2 == 0) ? 0 : 1);
            tick(); mem_resp = 0; #1;
            chk("rr_done_quiet", {i_resp, d_resp, mem_read}, 0);
            tick();
        end
        i_read = 0; d_read = 0;
        tick(); tick();
`else
        tick(); #1;
        chk("fp_first_d_addr", mem_address, 32'h2000);
        chk("fp_first_d_read", mem_read, 1);
        tick(); mem_resp = 1; mem_rdata = PAT_B; #1;
        chk("fp_d_resp1", d_resp, 1);
        chk("fp_d_rdata1", d_rdata, PAT_B);
        chk("fp_i_quiet1", i_resp, 0);
        tick(); mem_resp = 0; d_address = 32'h3000; #1;
        chk("fp_done1", mem_read, 0);
        tick(); #1;
        chk("fp_idle_bubble", mem_read, 0);
        tick(); #1;
        chk("fp_second_d_addr", mem_address, 32'h3000);
        mem_resp = 1; #1;
        chk("fp_d_resp2", d_resp, 1);
        chk("fp_i_starved", i_resp, 0);
        tick(); mem_resp = 0; d_read = 0;
        tick();
        tick(); #1;
        chk("fp_i_addr", mem_address, 32'h80);
        chk("fp_i_mem_read", mem_read, 1);
        mem_resp = 1; mem_rdata = PAT_A; #1;
        chk("fp_i_resp", i_resp, 1);
        chk("fp_i_d_quiet", d_resp, 0);
        tick(); mem_resp = 0; i_read = 0;
        tick();
`endif

        // Reset two cycles after grant
        tick(); i_read = 1; i_address = 32'h40;
        tick(); #1;
        chk("ro_mem_read_before", mem_read, 1);
        tick(); rst = 1;
        tick(); rst = 0; i_read = 0; #1;
        chk("ro_mem_read_dropped", mem_read, 0);
        chk("ro_mem_address_clr", mem_address, 0);
        mem_resp = 1; #1;
        chk("ro_stray_i_resp", i_resp, 0);
        chk("ro_stray_d_resp", d_resp, 0);
        tick(); #1;
        chk("ro_stray_idle_i_resp", i_resp, 0);
        chk("ro_idle_mem_read", mem_read, 0);
        tick(); mem_resp = 0;

        // d_read and d_write together behave as a write
        tick(); d_read = 1; d_write = 1; d_address = 32'h4000; d_wdata = PAT_C;
        tick(); #1;
        chk("rw_mem_write", mem_write, 1);
        chk("rw_mem_read", mem_read, 0);
        chk("rw_mem_wdata", mem_wdata, PAT_C);
        tick(); #1;
        chk("rw_mem_read_held", mem_read, 0);
        mem_resp = 1; #1;
        chk("rw_d_resp", d_resp, 1);
        chk("rw_mem_write_resp", mem_write, 1);
        tick(); mem_resp = 0; d_read = 0; d_write = 0; #1;
        chk("rw_done", {mem_read, mem_write}, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: i_read  input  1  I-cache line-fill request, held until i_resp.
REQ-004 SHALL have port: i_address  input  32  I-cache line address (bits [4:0] zero).
REQ-005 SHALL have port: i_rdata  output  256  line returned to I-cache.
REQ-006 SHALL have port: i_resp  output  1  one-cycle completion pulse to I-cache.
REQ-007 SHALL have port: d_read  input  1  D-cache line-fill request, held until d_resp.
REQ-008 SHALL have port: d_write  input  1  D-cache writeback request, held until d_resp.
REQ-009 SHALL have port: d_address  input  32  D-cache line address.
REQ-010 SHALL have port: d_wdata  input  256  writeback line.
REQ-011 SHALL have port: d_rdata  output  256  line returned to D-cache.
REQ-012 SHALL have port: d_resp  output  1  one-cycle completion pulse to D-cache.
REQ-013 SHALL have port: mem_read  output  1  line read toward cacheline adaptor.
REQ-014 SHALL have port: mem_write  output  1  line write toward cacheline adaptor.
REQ-015 SHALL have port: mem_address  output  32  line address toward adaptor.
REQ-016 SHALL have port: mem_wdata  output  256  line write data toward adaptor.
REQ-017 SHALL have port: mem_rdata  input  256  line read data from adaptor.
REQ-018 SHALL have port: mem_resp  input  1  one-cycle completion pulse from adaptor.

Function
REQ-019 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, DONE.
REQ-020 In IDLE, SHALL grant on the rising edge where any request is high: D request (d_read|d_write) -> SERVE_D, else i_read -> SERVE_I; no request -> stay IDLE.
REQ-021 At grant, SHALL latch address, op (read/write) and d_wdata into internal registers; mem_* outputs driven only from these registers.
REQ-022 If d_read and d_write both high at grant, SHALL treat as write (mem_write=1, mem_read=0).
REQ-023 In SERVE_I/SERVE_D, SHALL hold mem_read or mem_write (exactly one) high every cycle until mem_resp; mem_read and mem_write never both high.
REQ-024 On the cycle mem_resp=1, SHALL assert the granted side's *_resp combinationally the same cycle and drive *_rdata = mem_rdata; non-granted *_resp SHALL stay 0.
REQ-025 After mem_resp, SHALL enter DONE for exactly one cycle with all mem_* requests low, then IDLE (minimum 1 bubble; grant-to-resp latency = adaptor latency + 1 cycle).
REQ-026 i_rdata/d_rdata SHALL be don't-care except in the resp cycle; implementation SHALL drive mem_rdata to both.
REQ-027 mem_resp received in IDLE or DONE SHALL be ignored (no *_resp pulse).
REQ-028 A request deasserted before its resp (protocol violation) SHALL NOT abort the in-flight memory transaction.

Reset
REQ-029 On rst=1, SHALL enter IDLE next edge; mem_read=0, mem_write=0, i_resp=0, d_resp=0, mem_address=0, mem_wdata=0, round-robin pointer=favor D.
REQ-030 rst mid-transaction SHALL drop mem_read/mem_write on the following cycle and discard the pending grant; no *_resp issued for it.

Configuration
REQ-031 With macro CACHE_ARBITER_RR_EN defined, SHALL use round-robin: when both sides request in IDLE, grant the side not served by the most recent grant; single requester always granted.
REQ-032 Without CACHE_ARBITER_RR_EN, SHALL use fixed D-over-I priority per REQ-020; pointer register absent.

Verification
REQ-033 I-only: i_read=1, i_address=0x60 at t0; adaptor resp after 4 cycles with 0xAA..AA -> mem_read=1, mem_address=0x60 from t1; i_resp=1, i_rdata=0xAA..AA on resp cycle; mem_read=0 next cycle.
REQ-034 D writeback: d_write=1, d_address=0x1000, d_wdata=0x5555..55 -> mem_write=1, mem_wdata=0x5555..55 held until mem_resp; d_resp pulses once, i_resp stays 0.
REQ-035 Contention, fixed priority: i_read and d_read both high at t0 -> D served first, I granted in the IDLE cycle after DONE; two back-to-back D requests starve I until d_read drops.
REQ-036 Contention, CACHE_ARBITER_RR_EN: both requesting continuously -> grants alternate D, I, D, I; each *_resp pulses exactly once per grant.
REQ-037 Reset mid-op: rst=1 two cycles after grant -> mem_read=0 next cycle, state IDLE, no *_resp; stray mem_resp afterward produces no *_resp.
REQ-038 d_read and d_write both high at grant -> mem_write=1, mem_read=0 throughout transaction.
